// File: rtl/spgd_pkg.sv
// Shared SPGD definitions: FSM state encoding, default widths and midscale helper.
`timescale 1ns/1ps
package spgd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_POS,
    ST_WAIT_POS,
    ST_SET_NEG,
    ST_WAIT_NEG,
    ST_UPDATE
  } spgd_state_e;

  localparam int unsigned SPGD_DAC_WIDTH    = 14;
  localparam int unsigned SPGD_METRIC_WIDTH = 12;

  function automatic int unsigned spgd_midscale(input int unsigned width);
    return 32'd1 << (width - 1);
  endfunction

  localparam int unsigned SPGD_MIDSCALE = spgd_midscale(SPGD_DAC_WIDTH);

endpackage

// File: rtl/spgd_lfsr.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) that steps only on the advance strobe.
`timescale 1ns/1ps
module spgd_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        adv_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (adv_i) begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/spgd_sequencer.sv
// Two-channel SPGD sequencer: perturbs both DAC codes +/-DELTA, captures averaged
// metric for each sign, and steps the unperturbed codes along the measured gradient.
`timescale 1ns/1ps
module spgd_sequencer
  import spgd_pkg::*;
#(
  parameter int unsigned DAC_WIDTH     = SPGD_DAC_WIDTH,
  parameter int unsigned METRIC_WIDTH  = SPGD_METRIC_WIDTH,
  parameter int unsigned DELTA         = 64,
  parameter int unsigned GAIN_SHIFT    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                    ADC_CLK,
  input  logic                    RST,
  input  logic                    ENABLE,
  input  logic [METRIC_WIDTH-1:0] AVG_DATA,
  input  logic                    AVG_DONE,
  output logic                    AVG_RST,
  output logic [DAC_WIDTH-1:0]    DACA_CODE_OUT,
  output logic [DAC_WIDTH-1:0]    DACB_CODE_OUT,
  output logic [15:0]             ITER_COUNT,
  output logic                    BUSY
);

  localparam int unsigned SW = ((DAC_WIDTH > METRIC_WIDTH + 1) ? DAC_WIDTH : METRIC_WIDTH + 1) + 2;
  localparam int unsigned CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]     CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [DAC_WIDTH-1:0] MIDSCALE   = DAC_WIDTH'(spgd_midscale(DAC_WIDTH));
  localparam logic signed [SW-1:0] DAC_MAX    = SW'((64'd1 << DAC_WIDTH) - 64'd1);
  localparam logic signed [SW-1:0] DELTA_S    = SW'(DELTA);

  spgd_state_e state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    arm_q, arm_d;
  logic [DAC_WIDTH-1:0]    ua_q, ua_d, ub_q, ub_d;
  logic [DAC_WIDTH-1:0]    daca_q, daca_d, dacb_q, dacb_d;
  logic [METRIC_WIDTH-1:0] jpos_q, jpos_d, jneg_q, jneg_d;
  logic [15:0]             iter_q, iter_d;
  logic                    lfsr_adv;
  logic [15:0]             lfsr_w;
  logic                    unused_lfsr;

  logic signed [METRIC_WIDTH:0] diff, step;
  logic signed [SW-1:0]         step_ext;

  spgd_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (ADC_CLK),
    .rst_i   (RST),
    .adv_i   (lfsr_adv),
    .state_o (lfsr_w)
  );

  assign unused_lfsr = ^lfsr_w[15:2];

  // Saturating base +/- offset, clamped to the DAC code range.
  function automatic logic [DAC_WIDTH-1:0] sat_add(input logic [DAC_WIDTH-1:0] base,
                                                   input logic signed [SW-1:0] offs,
                                                   input logic negate);
    logic signed [SW-1:0] sum;
    sum = $signed({{(SW-DAC_WIDTH){1'b0}}, base}) + (negate ? -offs : offs);
    if (sum[SW-1]) begin
      return '0;
    end else if (sum > DAC_MAX) begin
      return '1;
    end
    return sum[DAC_WIDTH-1:0];
  endfunction

  always_comb begin
    diff     = $signed({1'b0, jpos_q}) - $signed({1'b0, jneg_q});
    step     = diff >>> GAIN_SHIFT;
    step_ext = $signed({{(SW-METRIC_WIDTH-1){step[METRIC_WIDTH]}}, step});
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = CNT_RELOAD;
    arm_d    = 1'b0;
    ua_d     = ua_q;
    ub_d     = ub_q;
    jpos_d   = jpos_q;
    jneg_d   = jneg_q;
    iter_d   = iter_q;
    lfsr_adv = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_SET_POS;
      end
      ST_SET_POS, ST_SET_NEG: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = (state_q == ST_SET_POS) ? ST_WAIT_POS : ST_WAIT_NEG;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      // arm_q is low on the first WAIT cycle so a result left over from the previous phase is skipped.
      ST_WAIT_POS, ST_WAIT_NEG: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (arm_q && AVG_DONE) begin
          if (state_q == ST_WAIT_POS) begin
            jpos_d  = AVG_DATA;
            state_d = ST_SET_NEG;
          end else begin
            jneg_d  = AVG_DATA;
            state_d = ST_UPDATE;
          end
        end else begin
          arm_d = 1'b1;
        end
      end
      ST_UPDATE: begin
        ua_d     = sat_add(ua_q, step_ext, ~lfsr_w[0]);
        ub_d     = sat_add(ub_q, step_ext, ~lfsr_w[1]);
        iter_d   = iter_q + 16'd1;
        lfsr_adv = 1'b1;
        state_d  = ENABLE ? ST_SET_POS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // DAC codes follow the current state, so they settle one cycle after each state entry.
  always_comb begin
    daca_d = daca_q;
    dacb_d = dacb_q;
    unique case (state_q)
      ST_IDLE: begin
        daca_d = ua_q;
        dacb_d = ub_q;
      end
      ST_SET_POS, ST_WAIT_POS: begin
        daca_d = sat_add(ua_q, DELTA_S, ~lfsr_w[0]);
        dacb_d = sat_add(ub_q, DELTA_S, ~lfsr_w[1]);
      end
      ST_SET_NEG, ST_WAIT_NEG: begin
        daca_d = sat_add(ua_q, DELTA_S, lfsr_w[0]);
        dacb_d = sat_add(ub_q, DELTA_S, lfsr_w[1]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_RELOAD;
      arm_q   <= 1'b0;
      ua_q    <= MIDSCALE;
      ub_q    <= MIDSCALE;
      daca_q  <= MIDSCALE;
      dacb_q  <= MIDSCALE;
      jpos_q  <= '0;
      jneg_q  <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      arm_q   <= arm_d;
      ua_q    <= ua_d;
      ub_q    <= ub_d;
      daca_q  <= daca_d;
      dacb_q  <= dacb_d;
      jpos_q  <= jpos_d;
      jneg_q  <= jneg_d;
      iter_q  <= iter_d;
    end
  end

  assign AVG_RST       = !(state_q == ST_WAIT_POS || state_q == ST_WAIT_NEG);
  assign BUSY          = (state_q != ST_IDLE);
  assign DACA_CODE_OUT = daca_q;
  assign DACB_CODE_OUT = dacb_q;
  assign ITER_COUNT    = iter_q;

endmodule

// File: tb/tb_spgd_sequencer.sv
// Scoreboard bench for spgd_sequencer: driver pushes expected codes per event, monitor pops and compares.
`timescale 1ns/1ps
module tb_spgd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        done = 1'b0;
  logic [11:0] data = '0;
  logic        avg_rst;
  logic        busy;
  logic [13:0] daca;
  logic [13:0] dacb;
  logic [15:0] iter_cnt;

  always #5 clk = ~clk;

  spgd_sequencer #(
    .DAC_WIDTH     (14),
    .METRIC_WIDTH  (12),
    .DELTA         (64),
    .GAIN_SHIFT    (4),
    .SETTLE_CYCLES (16),
    .LFSR_SEED     (16'hACE1)
  ) dut (
    .ADC_CLK       (clk),
    .RST           (rst),
    .ENABLE        (en),
    .AVG_DATA      (data),
    .AVG_DONE      (done),
    .AVG_RST       (avg_rst),
    .DACA_CODE_OUT (daca),
    .DACB_CODE_OUT (dacb),
    .ITER_COUNT    (iter_cnt),
    .BUSY          (busy)
  );

  typedef enum int {EV_RESET, EV_WAIT, EV_IDLE} ev_e;
  typedef struct {
    ev_e kind;
    int  a;
    int  b;
    int  iter;
    int  len;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  int ua, ub, iter;
  logic [15:0] lf;

  function automatic void check(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  function automatic int clamp(int v);
    if (v < 0) return 0;
    if (v > 16383) return 16383;
    return v;
  endfunction

  function automatic int floor16(int d);
    if (d >= 0) return d / 16;
    return -((-d + 15) / 16);
  endfunction

  function automatic void model_reset();
    ua = 8192; ub = 8192; iter = 0; lf = 16'hACE1;
  endfunction

  function automatic void push_wait(bit pos, int len);
    exp_t e;
    int sg, sa, sb;
    sg = pos ? 1 : -1;
    sa = lf[0] ? 1 : -1;
    sb = lf[1] ? 1 : -1;
    e.kind = EV_WAIT; e.a = clamp(ua + sg * sa * 64); e.b = clamp(ub + sg * sb * 64);
    e.iter = iter; e.len = len;
    q.push_back(e);
  endfunction

  function automatic void push_idle();
    exp_t e;
    e.kind = EV_IDLE; e.a = ua; e.b = ub; e.iter = iter; e.len = 0;
    q.push_back(e);
  endfunction

  function automatic void push_reset();
    exp_t e;
    e.kind = EV_RESET; e.a = 8192; e.b = 8192; e.iter = 0; e.len = 0;
    q.push_back(e);
  endfunction

  function automatic void model_update(int jp, int jn);
    int step, sa, sb;
    sa = lf[0] ? 1 : -1;
    sb = lf[1] ? 1 : -1;
    step = floor16(jp - jn);
    ua = clamp(ua + sa * step);
    ub = clamp(ub + sb * step);
    lf = {lf[14:0], ^(lf & 16'hB400)};
    iter = (iter + 1) & 16'hFFFF;
  endfunction

  task automatic wait_entry();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (!avg_rst && busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_entry_reached", int'(ok), 1);
  endtask

  task automatic respond(int stale, int real_v);
    done = 1'b1; data = 12'(stale);
    @(posedge clk); #1;
    data = 12'(real_v);
    @(posedge clk); #1;
    done = 1'b0; data = '0;
  endtask

  task automatic run_iter(int jp, int jn, int stale_p, int len_pos);
    push_wait(1'b1, len_pos);
    wait_entry();
    respond(stale_p, jp);
    push_wait(1'b0, 16);
    wait_entry();
    respond(jn, jn);
    model_update(jp, jn);
    @(posedge clk); #1;
  endtask

  task automatic go_idle();
    push_idle();
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: classifies DUT events and compares against the head of the queue.
  initial begin
    bit   prev_rst, prev_busy, prev_avg;
    int   run;
    exp_t e;
    prev_rst = 1'b0; prev_busy = 1'b0; prev_avg = 1'b1; run = 0;
    forever begin
      @(negedge clk);
      if (rst && !prev_rst) begin
        check("expect_queued", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("event_kind_reset", int'(EV_RESET), int'(e.kind));
          check("reset_daca", int'(daca), e.a);
          check("reset_dacb", int'(dacb), e.b);
          check("reset_avg_rst", int'(avg_rst), 1);
          check("reset_busy", int'(busy), 0);
          check("reset_iter", int'(iter_cnt), e.iter);
        end
      end else if (!rst && prev_busy && !busy) begin
        @(negedge clk);
        check("expect_queued", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("event_kind_idle", int'(EV_IDLE), int'(e.kind));
          check("idle_daca", int'(daca), e.a);
          check("idle_dacb", int'(dacb), e.b);
          check("idle_iter", int'(iter_cnt), e.iter);
          check("idle_avg_rst", int'(avg_rst), 1);
        end
      end else if (!rst && busy && prev_avg && !avg_rst) begin
        check("expect_queued", int'(q.size() != 0), 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("event_kind_wait", int'(EV_WAIT), int'(e.kind));
          check("wait_daca", int'(daca), e.a);
          check("wait_dacb", int'(dacb), e.b);
          check("wait_iter", int'(iter_cnt), e.iter);
          if (e.len != 0) check("settle_len", run, e.len);
        end
      end
      run = (busy && avg_rst) ? run + 1 : 0;
      prev_rst = rst; prev_busy = busy; prev_avg = avg_rst;
    end
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    model_reset();
    push_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // AVG_DONE held low: perturbed codes appear, FSM parks in WAIT_POS
    push_wait(1'b1, 16);
    en = 1'b1;
    wait_entry();
    repeat (30) @(posedge clk);
    #1;
    go_idle();

    en = 1'b1;
    run_iter(2000, 1000, 2000, 16);
    run_iter(100, 300, 4095, 0);
    run_iter(500, 3000, 500, 0);
    run_iter(1234, 1234, 1234, 0);
    run_iter(4095, 0, 4095, 0);

    // ENABLE dropped in WAIT_NEG: captured J_pos discarded, u/LFSR/count untouched
    push_wait(1'b1, 0);
    wait_entry();
    respond(777, 777);
    push_wait(1'b0, 16);
    wait_entry();
    go_idle();

    en = 1'b1;
    run_iter(600, 200, 600, 16);
    for (int k = 0; k < 36; k++) begin
      if (lf[0]) run_iter(4095, 0, 4095, 0);
      else       run_iter(0, 4095, 0, 0);
    end
    for (int k = 0; k < 36; k++) begin
      if (lf[1]) run_iter(0, 4095, 0, 0);
      else       run_iter(4095, 0, 4095, 0);
    end
    go_idle();

    // asynchronous reset in the middle of WAIT_POS
    en = 1'b1;
    push_wait(1'b1, 16);
    wait_entry();
    @(posedge clk);
    #3;
    push_reset();
    rst = 1'b1;
    en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    en = 1'b1;
    run_iter(2000, 1000, 2000, 16);
    go_idle();

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
